// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime parity/stop configuration latched at start-bit detection.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_cfg #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              rx,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  output logic [DATA_W-1:0] rx_dataOut,
  output logic              rx_doneTick,
  output logic              parity_err,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic              frame_err,
  output logic              break_tick
`else
  output logic              frame_err
`endif
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] TICK_MID = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam logic [2:0] S_BREAK  = 3'd5;
`endif

  logic [1:0]        r_sync;
  logic [1:0]        r_flush;
  logic              r_armed;
  logic [2:0]        r_state;
  logic [TW-1:0]     r_tick;
  logic [BW-1:0]     r_bit;
  logic              r_stop_n;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en_l;
  logic              r_par_odd_l;
  logic              r_stop2_l;
  logic              r_perr_acc;
  logic              r_ferr_acc;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_perr;
  logic              r_ferr;
`ifdef UART_RX_BREAK_DETECT_EN
  logic              r_zero;
  logic              r_brk;
`endif

  logic w_rx;
  logic w_end;
  logic w_ferr_now;
  assign w_rx       = r_sync[1];
  assign w_end      = s_tick && (r_tick == TICK_END);
  assign w_ferr_now = r_ferr_acc | ~w_rx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync      <= 2'b11;
      r_flush     <= 2'b00;
      r_armed     <= 1'b0;
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_stop_n    <= 1'b0;
      r_shift     <= '0;
      r_par_en_l  <= 1'b0;
      r_par_odd_l <= 1'b0;
      r_stop2_l   <= 1'b0;
      r_perr_acc  <= 1'b0;
      r_ferr_acc  <= 1'b0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_zero      <= 1'b0;
      r_brk       <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[0], rx};
      // Arm only once the synchronizer holds post-reset samples and the line is idle,
      // so a line still low from an interrupted frame cannot start a new one.
      r_flush <= {r_flush[0], 1'b1};
      if (r_flush[1] && w_rx) r_armed <= 1'b1;
      r_done  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_brk   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (r_armed && !w_rx) begin
            r_tick      <= '0;
            r_par_en_l  <= parity_en;
            r_par_odd_l <= parity_odd;
            r_stop2_l   <= stop2;
            r_perr_acc  <= 1'b0;
            r_ferr_acc  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_zero      <= 1'b1;
`endif
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (s_tick) begin
            if (r_tick == TICK_MID) begin
              r_tick  <= '0;
              r_bit   <= '0;
              r_state <= w_rx ? S_IDLE : S_DATA;
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_end) begin
            r_tick  <= '0;
            r_shift <= {w_rx, r_shift[DATA_W-1:1]};
            if (r_bit == BIT_LAST) begin
              r_stop_n <= 1'b0;
              r_state  <= r_par_en_l ? S_PARITY : S_STOP;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end else if (s_tick) begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_PARITY: begin
          if (w_end) begin
            r_tick     <= '0;
            r_perr_acc <= (^r_shift) ^ w_rx ^ r_par_odd_l;
`ifdef UART_RX_BREAK_DETECT_EN
            if (w_rx) r_zero <= 1'b0;
`endif
            r_state    <= S_STOP;
          end else if (s_tick) begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_STOP: begin
          if (w_end) begin
            r_tick <= '0;
            if (r_stop2_l && !r_stop_n) begin
              r_stop_n   <= 1'b1;
              r_ferr_acc <= w_ferr_now;
`ifdef UART_RX_BREAK_DETECT_EN
              if (w_rx) r_zero <= 1'b0;
`endif
            end else begin
`ifdef UART_RX_BREAK_DETECT_EN
              if (r_zero && !w_rx && (r_shift == '0)) begin
                r_brk   <= 1'b1;
                r_state <= S_BREAK;
              end else begin
                r_data  <= r_shift;
                r_perr  <= r_perr_acc;
                r_ferr  <= w_ferr_now;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
`else
              r_data  <= r_shift;
              r_perr  <= r_perr_acc;
              r_ferr  <= w_ferr_now;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
`endif
            end
          end else if (s_tick) begin
            r_tick <= r_tick + TW'(1);
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_dataOut  = r_data;
  assign rx_doneTick = r_done;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_tick  = r_brk;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomized self-checking bench for uart_rx_cfg; expectations come from frame-level rules.
module tb_uart_rx_cfg;
  localparam int TDIV   = 4;
  localparam int OVS    = 16;
  localparam int BITCLK = OVS * TDIV;

  logic       clk = 1'b0;
  logic       reset, s_tick, rx, parity_en, parity_odd, stop2;
  logic [7:0] rx_dataOut;
  logic       rx_doneTick, parity_err, frame_err;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       break_tick;
`endif
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int brk_cnt = 0;

  uart_rx_cfg #(.DATA_W(8), .OVS(OVS)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx_dataOut(rx_dataOut), .rx_doneTick(rx_doneTick),
    .parity_err(parity_err),
`ifdef UART_RX_BREAK_DETECT_EN
    .frame_err(frame_err), .break_tick(break_tick)
`else
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TDIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_doneTick === 1'b1) done_cnt++;
`ifdef UART_RX_BREAK_DETECT_EN
    if (break_tick === 1'b1) brk_cnt++;
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules for a frame as driven on the line.
  function automatic logic exp_perr(input logic pen, input logic podd,
                                    input logic [7:0] d, input logic pb);
    return pen && (((^d) ^ pb) != podd);
  endfunction

  function automatic logic exp_ferr(input logic st2, input logic s1, input logic s2);
    return !s1 || (st2 && !s2);
  endfunction

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  // A low stop bit returns high before the bit ends so the line edge is clean.
  task automatic send_stop(input logic s);
    if (s) hold(1'b1, BITCLK);
    else begin
      hold(1'b0, BITCLK * 3 / 4);
      hold(1'b1, BITCLK / 4);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic pb, input logic st2, input logic s1,
                            input logic s2, input logic scramble);
    parity_en = pen; parity_odd = podd; stop2 = st2;
    hold(1'b0, BITCLK);
    if (scramble) begin
      parity_en = ~pen; parity_odd = ~podd; stop2 = ~st2;
    end
    for (int i = 0; i < 8; i++) hold(d[i], BITCLK);
    if (pen) hold(pb, BITCLK);
    send_stop(s1);
    if (st2) send_stop(s2);
    hold(1'b1, 2 * BITCLK);
  endtask

  task automatic check_frame(input string name, input int d0, input logic [7:0] ed,
                             input logic ep, input logic ef);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s_done got %0d pulses exp 1", name, done_cnt - d0);
    end
    checks++;
    if (rx_dataOut !== ed) begin
      errors++; $display("FAIL %s_data got %h exp %h", name, rx_dataOut, ed);
    end
    checks++;
    if (parity_err !== ep) begin
      errors++; $display("FAIL %s_perr got %b exp %b", name, parity_err, ep);
    end
    checks++;
    if (frame_err !== ef) begin
      errors++; $display("FAIL %s_ferr got %b exp %b", name, frame_err, ef);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (BITCLK) @(posedge clk);
    #1;
    checks++;
    if (rx_dataOut !== 8'h00 || rx_doneTick !== 1'b0 || parity_err !== 1'b0 ||
        frame_err !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h done=%b perr=%b ferr=%b pulses=%0d exp all 0",
               rx_dataOut, rx_doneTick, parity_err, frame_err, done_cnt);
    end
  endtask

  task automatic test_8n1();
    int d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("8n1", d0, 8'h55, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    int d0 = done_cnt;
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("8e1_bad", d0, 8'hA3, 1'b1, 1'b0);
    d0 = done_cnt;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("8o1_ok", d0, 8'hA3, 1'b0, 1'b0);
  endtask

  task automatic test_stop2();
    int d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_frame("8n2_bad", d0, 8'h3C, 1'b0, 1'b1);
    d0 = done_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_frame("8n2_ok", d0, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    hold(1'b0, 4 * TDIV);
    hold(1'b1, 2 * BITCLK);
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL glitch_nodone got %0d pulses exp 0", done_cnt - d0);
    end
    d0 = done_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("after_glitch", d0, 8'h81, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'hF0;
    int d0 = done_cnt;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    hold(1'b0, BITCLK);
    for (int i = 0; i < 3; i++) hold(d[i], BITCLK);
    hold(d[3], BITCLK / 2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    hold(d[3], BITCLK / 2 - 1);
    for (int i = 4; i < 8; i++) hold(d[i], BITCLK);
    hold(1'b1, 3 * BITCLK);
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL midreset_nodone got %0d pulses exp 0", done_cnt - d0);
    end
    checks++;
    if (rx_dataOut !== 8'h00 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got data=%h perr=%b ferr=%b exp 0",
               rx_dataOut, parity_err, frame_err);
    end
    d0 = done_cnt;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("after_midreset", d0, 8'h0F, 1'b0, 1'b0);
  endtask

  task automatic test_cfg_latch();
    int d0 = done_cnt;
    // Parity pins flip after the start bit; the frame must still decode as 8E2.
    send_frame(8'h6B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_frame("cfg_latch", d0, 8'h6B, exp_perr(1'b1, 1'b0, 8'h6B, 1'b0), 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic pen, podd, st2, pb, s1, s2;
      int d0;
      d    = 8'($urandom_range(1, 255));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      st2  = 1'($urandom_range(0, 1));
      pb   = 1'($urandom_range(0, 1));
      s1   = ($urandom_range(0, 3) != 0);
      s2   = ($urandom_range(0, 3) != 0);
      d0   = done_cnt;
      send_frame(d, pen, podd, pb, st2, s1, s2, 1'b0);
      check_frame($sformatf("rand%0d", n), d0, d,
                  exp_perr(pen, podd, d, pb), exp_ferr(st2, s1, s2));
    end
  endtask

  task automatic test_break();
    logic [7:0] prev;
    int d0, b0;
    prev = rx_dataOut;
    d0 = done_cnt; b0 = brk_cnt;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    hold(1'b0, 12 * BITCLK);
`ifdef UART_RX_BREAK_DETECT_EN
    hold(1'b1, 2 * BITCLK);
    checks++;
    if (brk_cnt - b0 != 1) begin
      errors++; $display("FAIL break_pulse got %0d exp 1", brk_cnt - b0);
    end
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL break_nodone got %0d pulses exp 0", done_cnt - d0);
    end
    checks++;
    if (rx_dataOut !== prev) begin
      errors++; $display("FAIL break_data got %h exp %h", rx_dataOut, prev);
    end
    d0 = done_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("after_break", d0, 8'h5A, 1'b0, 1'b0);
`else
    checks++;
    if (brk_cnt != b0 || prev === 8'h00) begin
      errors++; $display("FAIL break_setup got prev=%h exp nonzero", prev);
    end
    check_frame("zero_frame", d0, 8'h00, 1'b0, 1'b1);
    rx = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    hold(1'b1, 2 * BITCLK);
`endif
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_glitch();
    test_reset_midframe();
    test_cfg_latch();
    test_random();
    test_break();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
